multi_pwm_gen: RTL

MULTI_PWM_GEN -- requirements
Module: multi_pwm_gen

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_duty_conv.sv | 38 +++
 rtl/multi_pwm_gen.sv | 100 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
// Defaults describe a 100 kHz PWM at 100 MHz with 12-bit signed duty samples.
package pwm_pkg;

  localparam int PWM_NCH    = 4;
  localparam int PWM_PERIOD = 1000;
  localparam int PWM_DW     = 12;
  localparam int PWM_DMIN   = 50;
  localparam int PWM_DMAX   = 900;

  // Duty counts are held wide enough for any period up to 2^16 clocks.
  localparam int DUTY_W = 16;

  typedef logic [DUTY_W-1:0]        duty_t;
  typedef logic signed [PWM_DW-1:0] sample_t;

  localparam int SAT_MAG  = 2 ** (PWM_DW - 1) - 1;
  localparam int DUTY_LO  = PWM_DMIN;
  localparam int DUTY_HI  = PWM_DMAX;

  function automatic int cnt_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

  function automatic int sat_mag(input int dw);
    return 2 ** (dw - 1) - 1;
  endfunction

endpackage

// File: rtl/pwm_duty_conv.sv
// Combinational sample-to-duty conversion: saturating magnitude, scale to the
// period, truncate, then clamp into the allowed duty window.
module pwm_duty_conv
  import pwm_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD,
  parameter int DW     = PWM_DW,
  parameter int DMIN   = PWM_DMIN,
  parameter int DMAX   = PWM_DMAX
) (
  input  logic signed [DW-1:0] sample,
  output duty_t                duty
);

  localparam int PW = DW + DUTY_W;
  localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        MAG_SAT  = DW'(sat_mag(DW));

  function automatic logic [DW-1:0] sat_abs(input logic signed [DW-1:0] x);
    if (x == MOST_NEG) return MAG_SAT;
    if (x < 0) return $unsigned(-x);
    return $unsigned(x);
  endfunction

  function automatic duty_t clamp_duty(input logic [PW-1:0] d);
    if (d < PW'(DMIN)) return duty_t'(DMIN);
    if (d > PW'(DMAX)) return duty_t'(DMAX);
    return duty_t'(d);
  endfunction

  logic [DW-1:0] mag;
  logic [PW-1:0] scaled;

  assign mag    = sat_abs(sample);
  assign scaled = (PW'(mag) * PW'(PERIOD)) >> (DW - 1);
  assign duty   = clamp_duty(scaled);

endmodule

// File: rtl/multi_pwm_gen.sv
// Multi-channel PWM generator with per-channel pending/active duty registers
// updated only at the period wrap. Define PWM_PHASE_STAGGER_EN to spread phases.
module multi_pwm_gen
  import pwm_pkg::*;
#(
  parameter int NCH    = PWM_NCH,
  parameter int PERIOD = PWM_PERIOD,
  parameter int DW     = PWM_DW,
  parameter int DMIN   = PWM_DMIN,
  parameter int DMAX   = PWM_DMAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [$clog2(NCH)-1:0]   s_ch,
  input  logic signed [DW-1:0]     s_data,
  output logic [NCH-1:0]           pwm_out,
  output logic                     period_tick
);

  localparam int CW = cnt_width(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
`ifdef PWM_PHASE_STAGGER_EN
  localparam bit STAGGER = 1'b1;
`else
  localparam bit STAGGER = 1'b0;
`endif

  logic [CW-1:0]  cnt;
  logic           wrap;
  logic           ch_ok;
  logic           accept;
  logic [NCH-1:0] pend_full;
  duty_t          pend   [NCH];
  duty_t          active [NCH];
  duty_t          conv_duty;

  // Per-channel counter: the global count advanced by the channel's phase offset.
  function automatic logic [CW-1:0] phase_cnt(input logic [CW-1:0] c, input int i);
    logic [CW:0] s;
    s = {1'b0, c} + (STAGGER ? (CW+1)'(i * (PERIOD / NCH)) : '0);
    if (s >= (CW+1)'(PERIOD)) s = s - (CW+1)'(PERIOD);
    return s[CW-1:0];
  endfunction

  assign wrap   = (cnt == LAST);
  assign ch_ok  = (int'(s_ch) < NCH);
  assign accept = s_valid && s_ready && ch_ok;

  always_comb begin
    s_ready = 1'b0;
    if (!rst) s_ready = ch_ok ? !pend_full[s_ch] : 1'b1;
  end

  pwm_duty_conv #(
    .PERIOD (PERIOD),
    .DW     (DW),
    .DMIN   (DMIN),
    .DMAX   (DMAX)
  ) u_conv (
    .sample (s_data),
    .duty   (conv_duty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= wrap ? '0 : cnt + 1'b1;
      period_tick <= wrap;
    end
  end

  // Commit at the wrap happens before the accept so a same-cycle accept stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= '0;
      pwm_out   <= '0;
      for (int i = 0; i < NCH; i++) active[i] <= duty_t'(DMIN);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wrap && pend_full[i]) begin
          active[i]    <= pend[i];
          pend_full[i] <= 1'b0;
        end
        if (accept && int'(s_ch) == i) pend_full[i] <= 1'b1;
        pwm_out[i] <= (duty_t'(phase_cnt(cnt, i)) < active[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (accept && int'(s_ch) == i) pend[i] <= conv_duty;
    end
  end

endmodule
